go_get_put_responder: RTL

GO_GET_PUT_RESPONDER -- requirements
Module: go_get_put_responder

---
 rtl/gpr_pkg.sv | 21 ++
 rtl/gpr_wdog.sv | 46 ++++
 rtl/go_get_put_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/gpr_pkg.sv
// ============================================================================
// gpr_pkg : shared state encoding and default limits for go_get_put_responder
// Revision: 1.0
// ============================================================================
`default_nettype none

package gpr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GET  = 2'd1,
    PUT  = 2'd2
  } gpr_state_e;

  localparam int GPR_GET_LEN   = 2;
  localparam int GPR_PUT_COUNT = 2;
  localparam int GPR_TIMEOUT   = 15;

endpackage

`default_nettype wire

// File: rtl/gpr_wdog.sv
// ============================================================================
// gpr_wdog : counts consecutive stalled PUT cycles and flags the one that
//            reaches the limit.
// Revision: 1.0
// ============================================================================
`default_nettype none

module gpr_wdog #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0] C_LAST = W'(TIMEOUT - 1);

  logic [W-1:0] wait_cnt_q;
  logic [W-1:0] wait_cnt_d;

  // expired marks the stalled cycle that brings the count up to TIMEOUT
  assign expired = inc && !clr && (wait_cnt_q == C_LAST);

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (clr) begin
      wait_cnt_d = '0;
    end else if (inc && !expired) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/go_get_put_responder.sv
// ============================================================================
// go_get_put_responder : go -> GET_LEN gets -> PUT_COUNT puts handshake FSM
// Optional checks enabled by macro GO_GET_PUT_RESPONDER_ASSERT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module go_get_put_responder
  import gpr_pkg::*;
#(
  parameter int GET_LEN   = GPR_GET_LEN,
  parameter int PUT_COUNT = GPR_PUT_COUNT,
  parameter int TIMEOUT   = GPR_TIMEOUT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic go,
  input  logic get,
  input  logic ready,
  input  logic stop,
  output logic put,
  output logic busy,
  output logic done,
  output logic aborted,
  output logic err
);

  localparam int GW = $clog2(GET_LEN + 1);
  localparam int PW = $clog2(PUT_COUNT + 1);
  localparam logic [GW-1:0] C_GET_LEN   = GW'(GET_LEN);
  localparam logic [PW-1:0] C_PUT_COUNT = PW'(PUT_COUNT);

  gpr_state_e    state_q, state_d;
  logic [GW-1:0] get_cnt_q, get_cnt_d;
  logic [PW-1:0] put_cnt_q, put_cnt_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;
  logic          err_q, err_d;
  logic          tmo_pend_q, tmo_pend_d;
  logic          wd_clr, wd_inc, wd_expired;

  assign put     = (state_q == PUT) && ready && !stop;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign aborted = aborted_q;
  assign err     = err_q;

  assign wd_clr = (state_q != PUT) || put || stop;
  assign wd_inc = (state_q == PUT) && !ready;

  gpr_wdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (wd_clr),
    .inc     (wd_inc),
    .expired (wd_expired)
  );

  always_comb begin
    state_d    = state_q;
    get_cnt_d  = get_cnt_q;
    put_cnt_d  = put_cnt_q;
    done_d     = 1'b0;
    aborted_d  = 1'b0;
    // a timeout is reported one cycle after the FSM has already returned to IDLE
    err_d      = tmo_pend_q;
    tmo_pend_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = GET;
          get_cnt_d = '0;
        end
      end
      GET: begin
        if (get) begin
          get_cnt_d = get_cnt_q + 1'b1;
          if (get_cnt_d == C_GET_LEN) begin
            state_d   = PUT;
            put_cnt_d = '0;
          end
        end else begin
          state_d = IDLE;
          err_d   = 1'b1;
        end
      end
      PUT: begin
        if (stop) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
        end else if (put) begin
          put_cnt_d = put_cnt_q + 1'b1;
          if (put_cnt_d == C_PUT_COUNT) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end else if (wd_expired) begin
          state_d    = IDLE;
          tmo_pend_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      get_cnt_q  <= '0;
      put_cnt_q  <= '0;
      done_q     <= 1'b0;
      aborted_q  <= 1'b0;
      err_q      <= 1'b0;
      tmo_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      get_cnt_q  <= get_cnt_d;
      put_cnt_q  <= put_cnt_d;
      done_q     <= done_d;
      aborted_q  <= aborted_d;
      err_q      <= err_d;
      tmo_pend_q <= tmo_pend_d;
    end
  end

`ifdef GO_GET_PUT_RESPONDER_ASSERT_EN
  localparam int C_PUT_WINDOW = TIMEOUT * PUT_COUNT + PUT_COUNT;

  a_xfer_completes: assert property (
    @(posedge clk) disable iff (!rst_n)
      (go && !busy) ##1 get [*GET_LEN] |->
        sync_reject_on(stop) (##1 (put [->PUT_COUNT] within 1'b1 [*C_PUT_WINDOW]))
  );

  a_put_implies_busy: assert property (
    @(posedge clk) disable iff (!rst_n) put |-> busy
  );
`endif

endmodule

`default_nettype wire
